// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, LSB first, one bit per
// clock. diff_out = a - b mod 2^WIDTH, borrow_out = 1 when a < b (unsigned).
//
// Optional feature (compile-time macro SUB_OVERFLOW_EN): adds overflow_out,
// the two's-complement overflow flag of the subtraction. The port and its
// logic exist only when the macro is defined.
//
// Handshake: start is a request that is accepted only in IDLE (when no
// operation is already queued) or in DONE. Acceptance loads the operands.
// The block then spends one IDLE cycle with the operands loaded ("armed"),
// followed by WIDTH SHIFT cycles with busy=1, and then one DONE cycle with
// done=1. done is the single-cycle result-valid strobe, and there is no
// back-pressure. diff_out and borrow_out (and overflow_out) change only on
// the SHIFT->DONE edge or on reset. start held high in DONE chains the next
// operation, so the period is WIDTH+2 cycles.
//
// fsm_state exposes the state register for debug: 0=IDLE, 1=SHIFT, 2=DONE.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
`ifdef SUB_OVERFLOW_EN
  output logic             overflow_out,
`endif
  output logic [1:0]       fsm_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             accept;
  logic             armed_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-2:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             last_bit;
  logic             a0, b0, d_bit, br_next;
  logic [WIDTH-1:0] shifted;
`ifdef SUB_OVERFLOW_EN
  logic             a_msb_q, b_msb_q;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and start acceptance
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed_q)    state_d = SHIFT;
        else if (start) accept  = 1'b1;
      end
      SHIFT: begin
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        accept  = start;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One full-subtractor bit slice on the current operand LSBs
  always_comb begin
    a0       = a_q[0];
    b0       = b_q[0];
    d_bit    = a0 ^ b0 ^ br_q;
    br_next  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    shifted  = {d_bit, res_q};
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  // Operand/result datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      armed_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      br_q         <= 1'b0;
      diff_out     <= '0;
      borrow_out   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      overflow_out <= 1'b0;
`endif
    end else if (accept) begin
      armed_q <= 1'b1;
      a_q     <= a_in;
      b_q     <= b_in;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      a_msb_q <= a_in[WIDTH-1];
      b_msb_q <= b_in[WIDTH-1];
`endif
    end else begin
      armed_q <= 1'b0;
      if (state_q == SHIFT) begin
        a_q   <= a_q >> 1;
        b_q   <= b_q >> 1;
        res_q <= shifted[WIDTH-1:1];
        br_q  <= br_next;
        cnt_q <= cnt_q + CW'(1);
        if (last_bit) begin
          diff_out     <= shifted;
          borrow_out   <= br_next;
`ifdef SUB_OVERFLOW_EN
          overflow_out <= (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
        end
      end
    end
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign fsm_state = state_q;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, named clock and reset.
REQ-002 The module SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request one subtraction; sampled only when the FSM is in IDLE or DONE.
REQ-006 a_in  input  WIDTH  minuend; captured on an accepted start.
REQ-007 b_in  input  WIDTH  subtrahend; captured on an accepted start.
REQ-008 busy  output  1  high while in SHIFT.
REQ-009 done  output  1  single-cycle pulse; the result is valid.
REQ-010 diff_out  output  WIDTH  registered a-b modulo 2^WIDTH; held until the next completion.
REQ-011 borrow_out  output  1  registered final borrow (1 when a<b, unsigned); held with diff_out.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE; busy SHALL be high only in SHIFT, and done SHALL be high only in DONE.
REQ-013 In IDLE or DONE, start=1 SHALL load the operand shift registers and clear the borrow flop and the bit counter, then move to SHIFT on the next edge.
REQ-014 In DONE with start=0, the FSM SHALL return to IDLE; DONE therefore lasts exactly one cycle.
REQ-015 Each SHIFT cycle SHALL process one bit, LSB first: d = a0^b0^br; br_next = (~a0&b0) | (~(a0^b0)&br).
REQ-016 d SHALL be shifted into the result register from the MSB side, and both operand registers SHALL shift right by one.
REQ-017 SHIFT SHALL last exactly WIDTH cycles, counted by a bit counter that runs 0..WIDTH-1 and transitions to DONE when it reaches WIDTH-1.
REQ-018 On the SHIFT->DONE edge, the completed result SHALL be written to diff_out and the final borrow to borrow_out.
REQ-019 Latency: if start is sampled at edge k, done SHALL be high in the cycle after edge k+1+WIDTH; back-to-back operations SHALL be supported via start in DONE.
REQ-020 start SHALL be ignored while in SHIFT; a_in and b_in changes during SHIFT SHALL NOT affect the result.
REQ-021 diff_out and borrow_out SHALL remain stable except on the SHIFT->DONE edge and on reset.

Reset
REQ-022 On reset, the FSM SHALL go to IDLE, and the bit counter, borrow flop, operand registers, diff_out, borrow_out, busy, done and overflow_out SHALL all be 0.
REQ-023 Reset SHALL override start.
REQ-024 Reset asserted mid-SHIFT SHALL abort the operation, with no done pulse and no output update.

Configuration
REQ-025 The macro SUB_OVERFLOW_EN SHALL control a signed-overflow output.
REQ-026 When SUB_OVERFLOW_EN is defined, the module SHALL add output overflow_out (1 bit), registered together with diff_out: 1 when a_msb!=b_msb and diff_msb!=a_msb (two's-complement overflow).
REQ-027 When SUB_OVERFLOW_EN is undefined, the port SHALL be absent and no overflow logic SHALL be present.

Verification (WIDTH=8)
REQ-028 a=0x05, b=0x03, start 1 cycle -> busy for 8 cycles, done pulse 1 cycle, diff_out=0x02, borrow_out=0.
REQ-029 a=0x03, b=0x05 -> diff_out=0xFE, borrow_out=1; a=0x00, b=0x00 -> diff_out=0x00, borrow_out=0.
REQ-030 With SUB_OVERFLOW_EN defined, a=0x80, b=0x01 -> diff_out=0x7F, overflow_out=1, borrow_out=0; a=0x7F, b=0x01 -> overflow_out=0.
REQ-031 start=1 held continuously with a=0x10, b=0x01 -> done every 10 cycles; start pulses and a_in/b_in changes during SHIFT are ignored; diff_out=0x0F.
REQ-032 Reset asserted in the 4th SHIFT cycle -> next cycle is IDLE, all outputs 0, no done pulse; a following start with a=0xFF, b=0xFF -> diff_out=0x00, borrow_out=0.
